// File: rtl/scan_bitmap_counter.sv
// scan_bitmap_counter: pipelined popcount of per-cache-line result bitmaps, accumulated into one partition total.
// Define SCAN_CNT_PER_CL_EN to expose the per-beat count stream (cl_cnt_valid/cl_cnt_data/cl_cnt_idx).
module scan_bitmap_counter #(
  parameter int CL_BITS = 512,
  parameter int CNT_W   = 32,
  parameter int CLS_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CLS_W-1:0]   total_cls,
  input  logic               bm_valid,
  output logic               bm_ready,
  input  logic [CL_BITS-1:0] bm_data,
  output logic               cnt_valid,
  input  logic               cnt_ready,
  output logic [CNT_W-1:0]   cnt_data,
`ifdef SCAN_CNT_PER_CL_EN
  output logic               cl_cnt_valid,
  output logic [9:0]         cl_cnt_data,
  output logic [CLS_W-1:0]   cl_cnt_idx,
`endif
  output logic               busy
);

  localparam int SLICES = CL_BITS / 32;
  localparam int SUM_W  = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  state_t             r_state;
  logic [CLS_W-1:0]   r_total;
  logic [CLS_W-1:0]   r_beat_cnt;
  logic               r_s1_valid;
  logic               r_s2_valid;
  logic [5:0]         r_s1_cnt [SLICES];
  logic [SUM_W-1:0]   r_s2_sum;
  logic [CNT_W-1:0]   r_acc;

  logic               w_accept;
  logic [CLS_W-1:0]   w_beat_nxt;
  logic [SUM_W-1:0]   w_slice_sum;

  assign w_accept   = bm_valid && bm_ready;
  assign w_beat_nxt = r_beat_cnt + {{(CLS_W-1){1'b0}}, 1'b1};

  // Stage-2 adder tree over the registered slice counts.
  always_comb begin
    w_slice_sum = {SUM_W{1'b0}};
    for (int i = 0; i < SLICES; i++) begin
      w_slice_sum = w_slice_sum + {{(SUM_W-6){1'b0}}, r_s1_cnt[i]};
    end
  end

  // Two-stage popcount pipeline; runs freely, valids follow the accepted beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_sum   <= {SUM_W{1'b0}};
      for (int i = 0; i < SLICES; i++) begin
        r_s1_cnt[i] <= 6'd0;
      end
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      if (w_accept) begin
        for (int i = 0; i < SLICES; i++) begin
          r_s1_cnt[i] <= popcnt32(bm_data[i*32 +: 32]);
        end
      end
      if (r_s1_valid) begin
        r_s2_sum <= w_slice_sum;
      end
    end
  end

  // Partition control FSM with registered handshake outputs and accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_total    <= {CLS_W{1'b0}};
      r_beat_cnt <= {CLS_W{1'b0}};
      r_acc      <= {CNT_W{1'b0}};
      bm_ready   <= 1'b0;
      cnt_valid  <= 1'b0;
      cnt_data   <= {CNT_W{1'b0}};
      busy       <= 1'b0;
    end else begin
      // Start clears below take priority; the pipeline is empty in IDLE anyway.
      if (r_s2_valid) begin
        r_acc <= r_acc + {{(CNT_W-SUM_W){1'b0}}, r_s2_sum};
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_total    <= total_cls;
            r_beat_cnt <= {CLS_W{1'b0}};
            r_acc      <= {CNT_W{1'b0}};
            busy       <= 1'b1;
            if (total_cls == {CLS_W{1'b0}}) begin
              r_state   <= S_DONE;
              cnt_valid <= 1'b1;
              cnt_data  <= {CNT_W{1'b0}};
            end else begin
              r_state  <= S_ACCUM;
              bm_ready <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_beat_cnt <= w_beat_nxt;
            if (w_beat_nxt == r_total) begin
              r_state  <= S_DRAIN;
              bm_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Both stages empty means the last accumulate has already landed.
          if (!r_s1_valid && !r_s2_valid) begin
            r_state   <= S_DONE;
            cnt_valid <= 1'b1;
            cnt_data  <= r_acc;
          end
        end
        S_DONE: begin
          if (cnt_ready) begin
            r_state   <= S_IDLE;
            cnt_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          bm_ready  <= 1'b0;
          cnt_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCAN_CNT_PER_CL_EN
  logic [CLS_W-1:0] r_s1_idx;
  logic [CLS_W-1:0] r_s2_idx;

  // Beat index travels alongside the popcount so each stage-2 result is tagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_idx <= {CLS_W{1'b0}};
      r_s2_idx <= {CLS_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_s1_idx <= r_beat_cnt;
      end
      if (r_s1_valid) begin
        r_s2_idx <= r_s1_idx;
      end
    end
  end

  assign cl_cnt_valid = r_s2_valid;
  assign cl_cnt_data  = r_s2_sum;
  assign cl_cnt_idx   = r_s2_idx;
`endif

endmodule

// File: tb/tb_scan_bitmap_counter.sv
// Scoreboard bench for scan_bitmap_counter: expected totals queued at start, checked at cnt_valid.
// With SCAN_CNT_PER_CL_EN defined, per-beat counts are also scoreboarded.
module tb_scan_bitmap_counter;

  localparam int CL_BITS = 512;
  localparam int CNT_W   = 32;
  localparam int CLS_W   = 7;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [CLS_W-1:0]   total_cls = '0;
  logic               bm_valid = 1'b0;
  logic               bm_ready;
  logic [CL_BITS-1:0] bm_data = '0;
  logic               cnt_valid;
  logic               cnt_ready = 1'b0;
  logic [CNT_W-1:0]   cnt_data;
  logic               busy;
`ifdef SCAN_CNT_PER_CL_EN
  logic               cl_cnt_valid;
  logic [9:0]         cl_cnt_data;
  logic [CLS_W-1:0]   cl_cnt_idx;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int lat;
  int a0;

  logic [CNT_W-1:0]   q_exp [$];
  logic [CL_BITS-1:0] beats [0:127];

`ifdef SCAN_CNT_PER_CL_EN
  typedef struct {
    int cnt;
    int idx;
    int due;
  } cl_t;
  cl_t q_cl [$];
`endif

  scan_bitmap_counter #(
    .CL_BITS(CL_BITS),
    .CNT_W  (CNT_W),
    .CLS_W  (CLS_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .total_cls   (total_cls),
    .bm_valid    (bm_valid),
    .bm_ready    (bm_ready),
    .bm_data     (bm_data),
    .cnt_valid   (cnt_valid),
    .cnt_ready   (cnt_ready),
    .cnt_data    (cnt_data),
`ifdef SCAN_CNT_PER_CL_EN
    .cl_cnt_valid(cl_cnt_valid),
    .cl_cnt_data (cl_cnt_data),
    .cl_cnt_idx  (cl_cnt_idx),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && bm_valid && bm_ready) n_acc <= n_acc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

`ifdef SCAN_CNT_PER_CL_EN
  always @(negedge clk) begin
    if (reset && cl_cnt_valid) begin
      cl_t e;
      check_val("cl_pending", q_cl.size() > 0, 1);
      if (q_cl.size() > 0) begin
        e = q_cl.pop_front();
        check_val("cl_data", cl_cnt_data, e.cnt);
        check_val("cl_idx", cl_cnt_idx, e.idx);
        check_val("cl_time", cyc, e.due);
      end
    end
  end
`endif

  task automatic start_part(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += $countones(beats[i]);
    q_exp.push_back(CNT_W'(s));
    start = 1'b1;
    total_cls = CLS_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_beats(input int n, input bit gaps, input bit extra);
    int idx = 0;
    int guard = 0;
    bit take;
    while (idx < n && guard < 2000) begin
      bm_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bm_data  = beats[idx];
      take     = bm_valid && bm_ready;
`ifdef SCAN_CNT_PER_CL_EN
      if (take) q_cl.push_back('{$countones(beats[idx]), idx, cyc + 2});
`endif
      @(negedge clk);
      guard++;
      if (take) idx++;
    end
    check_val("beats_sent", idx, n);
    bm_valid = extra;
  endtask

  task automatic wait_done(input int budget, output int l);
    l = 1;
    while (!cnt_valid && l < budget) begin
      @(negedge clk);
      l++;
    end
    check_val("done_seen", cnt_valid, 1);
  endtask

  task automatic finish_total(input int hold, input bit pulse);
    logic [CNT_W-1:0] exp;
    check_val("sb_pending", q_exp.size() > 0, 1);
    exp = (q_exp.size() > 0) ? q_exp.pop_front() : '0;
    check_val("total", cnt_data, exp);
    for (int i = 0; i < hold; i++) begin
      cnt_ready = 1'b0;
      start = pulse && (i == 4);
      @(negedge clk);
      check_val("hold_valid", cnt_valid, 1);
      check_val("hold_data", cnt_data, exp);
    end
    cnt_ready = 1'b1;
    start = pulse;
    @(negedge clk);
    cnt_ready = 1'b0;
    start = 1'b0;
    check_val("release_valid", cnt_valid, 0);
    check_val("release_busy", busy, 0);
    @(negedge clk);
    check_val("idle_busy", busy, 0);
    check_val("idle_ready", bm_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_ready", bm_ready, 0);
    check_val("rst_valid", cnt_valid, 0);
    check_val("rst_data", cnt_data, 0);
    check_val("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);

    // Mixed beats: 512 + 0 + 4 + 1 = 517.
    beats[0] = '1;
    beats[1] = '0;
    beats[2] = 512'hF;
    beats[3] = {1'b1, 511'd0};
    start_part(4);
    check_val("ready_accum", bm_ready, 1);
    check_val("busy_accum", busy, 1);
    run_beats(4, 1'b0, 1'b0);
    check_val("ready_drain", bm_ready, 0);
    check_val("busy_drain", busy, 1);
    wait_done(20, lat);
    check_val("latency", (lat >= 3) && (lat <= 4), 1);
    check_val("ready_done", bm_ready, 0);
    finish_total(0, 1'b0);

    // Empty partition goes straight to DONE and accepts nothing.
    a0 = n_acc;
    bm_valid = 1'b1;
    start_part(0);
    check_val("zero_done", cnt_valid, 1);
    finish_total(0, 1'b0);
    bm_valid = 1'b0;
    check_val("zero_accepted", n_acc - a0, 0);

    // Full partition with random gaps, plus a 128th beat held valid.
    for (int i = 0; i < 128; i++) beats[i] = '1;
    a0 = n_acc;
    start_part(127);
    run_beats(127, 1'b1, 1'b1);
    wait_done(20, lat);
    check_val("full_accepted", n_acc - a0, 127);
    finish_total(0, 1'b0);
    check_val("no_128th", n_acc - a0, 127);
    bm_valid = 1'b0;

    // Backpressure hold with ignored start, then a fresh small partition.
    beats[0] = {16{32'h0000_00FF}};
    beats[1] = 512'h3;
    start_part(2);
    run_beats(2, 1'b0, 1'b0);
    wait_done(20, lat);
    finish_total(10, 1'b1);
    beats[0] = 512'h7;
    start_part(1);
    run_beats(1, 1'b0, 1'b0);
    wait_done(20, lat);
    finish_total(0, 1'b0);

    // Asynchronous reset in the middle of ACCUM.
    for (int i = 0; i < 4; i++) beats[i] = '1;
    start = 1'b1;
    total_cls = 7'd4;
    @(negedge clk);
    start = 1'b0;
    run_beats(2, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_val("arst_ready", bm_ready, 0);
    check_val("arst_valid", cnt_valid, 0);
    check_val("arst_data", cnt_data, 0);
    check_val("arst_busy", busy, 0);
`ifdef SCAN_CNT_PER_CL_EN
    check_val("arst_cl_valid", cl_cnt_valid, 0);
    check_val("arst_cl_data", cl_cnt_data, 0);
    check_val("arst_cl_idx", cl_cnt_idx, 0);
    q_cl.delete();
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_ready", bm_ready, 0);

    // Fresh partition after reset: 5 + 0 + 512 = 517.
    beats[0] = 512'h1F;
    beats[1] = '0;
    beats[2] = '1;
    start_part(3);
    run_beats(3, 1'b0, 1'b0);
    wait_done(20, lat);
    finish_total(0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("sb_drained", q_exp.size(), 0);
`ifdef SCAN_CNT_PER_CL_EN
    check_val("cl_drained", q_cl.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
